io_regfile: RTL and testbench

Parametrised successor to the CPU register file. It merges general-purpose registers with memory-mapped I/O registers in one block: a sampled ADC capture register, a PWM duty register driving an on-block PWM generator, and a status register. It adds three things the current file lacks: a sample-ready/overrun handshake, glitch-free PWM duty updates, and write-to-read bypass. It sits between the processor's decode/writeback stages and the board pins.

---
 rtl/io_regfile_pkg.sv | 13 +
 rtl/io_regfile_pwm_gen.sv | 43 ++++
 rtl/io_regfile.sv | 117 +++++++++++
 tb/tb_io_regfile.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_regfile_pkg.sv
// Shared constants for the I/O register file: default register map and status bit layout.
package io_regfile_pkg;

  localparam int DEF_ADC_REG  = 1;
  localparam int DEF_PWM_REG  = 2;
  localparam int DEF_STAT_REG = 8;

  localparam int STAT_READY  = 0;
  localparam int STAT_OVR    = 1;
  localparam int STAT_REST   = 2;
  localparam int STAT_ACTIVE = 3;

endpackage

// File: rtl/io_regfile_pwm_gen.sv
// PWM generator: free-running period counter with a duty shadow that only reloads at the period
// boundary, so a duty change never truncates or stretches the pulse in flight.
module pwm_gen
  import io_regfile_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int PWM_PERIOD = 500000
) (
  input  logic              clock,
  input  logic              ctrl_reset_n,
  input  logic [DATA_W-1:0] duty,
  output logic              pwm_out
);

  localparam int CNT_W = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shadow_q, shadow_d;
  logic              pwm_q, pwm_d, wrap;

  // pwm_q is computed from next-state values so it always equals (cnt_q < shadow_q).
  always_comb begin
    wrap     = (cnt_q == CNT_W'(PWM_PERIOD - 1));
    cnt_d    = wrap ? '0 : cnt_q + CNT_W'(1);
    shadow_d = wrap ? duty : shadow_q;
    pwm_d    = (DATA_W'(cnt_d) < shadow_d);
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      pwm_q    <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      pwm_q    <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: rtl/io_regfile.sv
// Register file merged with memory-mapped I/O: ADC capture with ready/overrun handshake,
// PWM duty register feeding pwm_gen, status register, and write-to-read bypass.
module io_regfile
  import io_regfile_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int ADC_W      = 8,
  parameter int SAMPLE_DIV = 500,
  parameter int PWM_PERIOD = 500000,
  parameter int ADC_REG    = DEF_ADC_REG,
  parameter int PWM_REG    = DEF_PWM_REG,
  parameter int STAT_REG   = DEF_STAT_REG
) (
  input  logic              clock,
  input  logic              ctrl_reset_n,
  input  logic              ctrl_writeEnable,
  input  logic [ADDR_W-1:0] ctrl_writeReg,
  input  logic [DATA_W-1:0] data_writeReg,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  input  logic              ctrl_readAck,
  output logic [DATA_W-1:0] data_readRegA,
  output logic [DATA_W-1:0] data_readRegB,
  input  logic [ADC_W-1:0]  adc_in,
  input  logic              rest,
  input  logic              active,
  output logic              pwm_out
);

  localparam int NREGS = 2 ** ADDR_W;
  localparam int SMP_W = $clog2(SAMPLE_DIV);
  localparam logic [ADDR_W-1:0] ADC_IDX  = ADDR_W'(ADC_REG);
  localparam logic [ADDR_W-1:0] PWM_IDX  = ADDR_W'(PWM_REG);
  localparam logic [ADDR_W-1:0] STAT_IDX = ADDR_W'(STAT_REG);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [SMP_W-1:0]  smp_cnt_q, smp_cnt_d;
  logic              ready_q, ready_d, ovr_q, ovr_d;
  logic [1:0]        rest_sync_q, active_sync_q;
  logic              capture, w1c_hit, gp_write;
  logic [DATA_W-1:0] stat_word;

  // NOTE: every variable gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    stat_word = '0;
    capture   = (smp_cnt_q == SMP_W'(SAMPLE_DIV - 1));
    smp_cnt_d = capture ? '0 : smp_cnt_q + SMP_W'(1);
    w1c_hit   = ctrl_writeEnable && (ctrl_writeReg == STAT_IDX);
    gp_write  = ctrl_writeEnable && (ctrl_writeReg != '0) &&
                (ctrl_writeReg != ADC_IDX) && (ctrl_writeReg != STAT_IDX);

    // Set beats clear for both handshake flags when they land on the same edge.
    ready_d = ready_q;
    if (capture)
      ready_d = 1'b1;
    else if ((ctrl_readAck && ctrl_readRegA == ADC_IDX) || (w1c_hit && data_writeReg[STAT_READY]))
      ready_d = 1'b0;

    ovr_d = ovr_q;
    if (capture && ready_q)
      ovr_d = 1'b1;
    else if (w1c_hit && data_writeReg[STAT_OVR])
      ovr_d = 1'b0;

    stat_word[STAT_READY]  = ready_q;
    stat_word[STAT_OVR]    = ovr_q;
    stat_word[STAT_REST]   = rest_sync_q[1];
    stat_word[STAT_ACTIVE] = active_sync_q[1];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      // NOTE: the register array is cleared on reset because software relies on zeroed registers.
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      smp_cnt_q     <= '0;
      ready_q       <= 1'b0;
      ovr_q         <= 1'b0;
      rest_sync_q   <= '0;
      active_sync_q <= '0;
    end else begin
      smp_cnt_q     <= smp_cnt_d;
      ready_q       <= ready_d;
      ovr_q         <= ovr_d;
      rest_sync_q   <= {rest_sync_q[0], rest};
      active_sync_q <= {active_sync_q[0], active};
      if (gp_write) regs_q[ctrl_writeReg] <= data_writeReg;
      if (capture)  regs_q[ADC_IDX] <= DATA_W'(adc_in);
    end
  end

  // r0, the ADC capture and the status word bypass nothing: they are not plainly writable.
  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] idx);
    if (idx == '0)                                          return '0;
    else if (idx == ADC_IDX)                                return regs_q[ADC_IDX];
    else if (idx == STAT_IDX)                               return stat_word;
    else if (ctrl_writeEnable && idx == ctrl_writeReg)      return data_writeReg;
    else                                                    return regs_q[idx];
  endfunction

  always_comb begin
    data_readRegA = read_port(ctrl_readRegA);
    data_readRegB = read_port(ctrl_readRegB);
  end

  pwm_gen #(
    .DATA_W    (DATA_W),
    .PWM_PERIOD(PWM_PERIOD)
  ) u_pwm_gen (
    .clock       (clock),
    .ctrl_reset_n(ctrl_reset_n),
    .duty        (regs_q[PWM_IDX]),
    .pwm_out     (pwm_out)
  );

endmodule

// File: tb/tb_io_regfile.sv
// Directed bench for io_regfile with a scoreboard queue: expectations are pushed as stimulus
// is driven and popped when the corresponding DUT output is sampled.
module tb_io_regfile;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 5;
  localparam int ADC_W      = 8;
  localparam int SAMPLE_DIV = 4;
  localparam int PWM_PERIOD = 10;

  logic              clock = 1'b0;
  logic              ctrl_reset_n;
  logic              ctrl_writeEnable;
  logic [ADDR_W-1:0] ctrl_writeReg;
  logic [DATA_W-1:0] data_writeReg;
  logic [ADDR_W-1:0] ctrl_readRegA;
  logic [ADDR_W-1:0] ctrl_readRegB;
  logic              ctrl_readAck;
  logic [DATA_W-1:0] data_readRegA;
  logic [DATA_W-1:0] data_readRegB;
  logic [ADC_W-1:0]  adc_in;
  logic              rest;
  logic              active;
  logic              pwm_out;

  io_regfile #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .ADC_W     (ADC_W),
    .SAMPLE_DIV(SAMPLE_DIV),
    .PWM_PERIOD(PWM_PERIOD),
    .ADC_REG   (1),
    .PWM_REG   (2),
    .STAT_REG  (8)
  ) dut (
    .clock           (clock),
    .ctrl_reset_n    (ctrl_reset_n),
    .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg   (ctrl_writeReg),
    .data_writeReg   (data_writeReg),
    .ctrl_readRegA   (ctrl_readRegA),
    .ctrl_readRegB   (ctrl_readRegB),
    .ctrl_readAck    (ctrl_readAck),
    .data_readRegA   (data_readRegA),
    .data_readRegB   (data_readRegB),
    .adc_in          (adc_in),
    .rest            (rest),
    .active          (active),
    .pwm_out         (pwm_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    string             tag;
    logic [DATA_W-1:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp   = 0;
  int   n_bad   = 0;
  int   cyc     = 0;
  bit   chk_pwm = 1'b0;

  task automatic expect_val(input string tag, input logic [DATA_W-1:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic compare(input logic [DATA_W-1:0] obs);
    exp_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $error("FAIL scoreboard_empty: observed %h, no expectation queued", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val)
      else begin
        n_bad++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  // Expected PWM level per cycle for the duty schedule written below (period 10).
  function automatic bit pwm_expect(input int c);
    if (c < 10) return 1'b0;
    if (c < 20) return (c - 10) < 3;
    if (c < 30) return (c - 20) < 7;
    if (c < 40) return 1'b0;
    return 1'b1;
  endfunction

  task automatic step();
    @(posedge clock);
    #2;
    cyc++;
    if (chk_pwm) begin
      expect_val($sformatf("pwm_c%0d", cyc), DATA_W'(pwm_expect(cyc)));
      compare(DATA_W'(pwm_out));
    end
  endtask

  task automatic go_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic wr(input logic we, input logic [ADDR_W-1:0] idx, input logic [DATA_W-1:0] d);
    ctrl_writeEnable = we;
    ctrl_writeReg    = idx;
    data_writeReg    = d;
  endtask

  task automatic rd(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b, input logic ack);
    ctrl_readRegA = a;
    ctrl_readRegB = b;
    ctrl_readAck  = ack;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ctrl_reset_n = 1'b0;
    adc_in       = 8'hA5;
    rest         = 1'b0;
    active       = 1'b0;
    wr(1'b0, '0, '0);
    rd(2, 8, 1'b0);
    step();
    step();
    #1;
    expect_val("reset_pwm_reg", 32'h0);  compare(data_readRegA);
    expect_val("reset_stat", 32'h0);     compare(data_readRegB);
    expect_val("reset_pwm_out", 32'h0);  compare(DATA_W'(pwm_out));

    cyc          = 0;
    ctrl_reset_n = 1'b1;
    chk_pwm      = 1'b1;

    // Bypass on the write cycle, then registered read, then r0 protection.
    wr(1'b1, 5, 32'hDEADBEEF); rd(5, 1, 1'b0); #1;
    expect_val("bypass_a_r5", 32'hDEADBEEF); compare(data_readRegA);
    expect_val("adc_before_cap", 32'h0);     compare(data_readRegB);
    step();
    wr(1'b1, 0, 32'hFFFFFFFF); rd(0, 5, 1'b0); #1;
    expect_val("r0_no_bypass", 32'h0);       compare(data_readRegA);
    expect_val("read_b_r5", 32'hDEADBEEF);   compare(data_readRegB);
    step();
    wr(1'b1, 1, 32'h12345678); rd(0, 1, 1'b0); #1;
    expect_val("r0_after_write", 32'h0);     compare(data_readRegA);
    expect_val("adc_no_bypass", 32'h0);      compare(data_readRegB);
    step();
    wr(1'b1, 2, 32'd3); rd(1, 8, 1'b0); #1;
    expect_val("adc_write_ignored", 32'h0);  compare(data_readRegA);
    expect_val("stat_before_cap", 32'h0);    compare(data_readRegB);

    // First capture lands on the 4th edge after release.
    step();
    wr(1'b0, '0, '0); rd(1, 8, 1'b1); #1;
    expect_val("adc_capture", 32'h000000A5); compare(data_readRegA);
    expect_val("stat_ready", 32'h1);         compare(data_readRegB);
    step();
    rd(1, 8, 1'b0); #1;
    expect_val("stat_after_ack", 32'h0);     compare(data_readRegB);
    expect_val("adc_hold", 32'h000000A5);    compare(data_readRegA);

    // Two captures without ack raise overrun; W1C clears only bit1.
    go_to(12);
    wr(1'b1, 8, 32'h2); #1;
    expect_val("stat_overrun", 32'h3);       compare(data_readRegB);
    step();
    wr(1'b0, '0, '0); #1;
    expect_val("stat_w1c_ovr", 32'h1);      compare(data_readRegB);

    // Ack on a capture edge: set wins, and the capture with ready=1 also sets overrun.
    go_to(15);
    wr(1'b1, 2, 32'd7); rd(1, 8, 1'b1); #1;
    expect_val("adc_read_ack", 32'h000000A5); compare(data_readRegA);
    expect_val("stat_pre_coincide", 32'h1);  compare(data_readRegB);
    step();
    wr(1'b1, 8, 32'h3); rd(1, 8, 1'b0); #1;
    expect_val("stat_coincide", 32'h3);      compare(data_readRegB);
    step();
    wr(1'b0, '0, '0); #1;
    expect_val("stat_w1c_all", 32'h0);       compare(data_readRegB);

    // Duty schedule: 0 from cycle 30, 10 from cycle 40, 0xFFFF from cycle 50.
    go_to(21);
    wr(1'b1, 2, 32'd0);
    step();
    wr(1'b0, '0, '0);
    go_to(31);
    wr(1'b1, 2, 32'd10);
    step();
    wr(1'b0, '0, '0);

    // Synchroniser latency on rest and active.
    go_to(33);
    rest = 1'b1;
    step(); #1;
    expect_val("rest_c1", 32'h0);            compare(data_readRegB & 32'h4);
    step(); #1;
    expect_val("rest_c2", 32'h4);            compare(data_readRegB & 32'h4);
    active = 1'b1;
    step(); #1;
    expect_val("active_c1", 32'h0);          compare(data_readRegB & 32'h8);
    step(); #1;
    expect_val("active_c2", 32'h8);          compare(data_readRegB & 32'h8);

    go_to(41);
    wr(1'b1, 2, 32'h0000FFFF);
    step();
    wr(1'b0, '0, '0);

    // Reset in the middle of a high pulse.
    go_to(52);
    ctrl_reset_n = 1'b0;
    rd(5, 8, 1'b0);
    chk_pwm = 1'b0;
    step(); #1;
    expect_val("midreset_pwm", 32'h0);       compare(DATA_W'(pwm_out));
    expect_val("midreset_r5", 32'h0);        compare(data_readRegA);
    expect_val("midreset_stat", 32'h0);      compare(data_readRegB);

    // Sample counter restarts: capture again exactly 4 edges after release.
    ctrl_reset_n = 1'b1;
    cyc = 0;
    rd(1, 8, 1'b0);
    go_to(3); #1;
    expect_val("restart_no_cap", 32'h0);     compare(data_readRegA);
    step(); #1;
    expect_val("restart_cap", 32'h000000A5); compare(data_readRegA);
    expect_val("restart_stat", 32'hD);       compare(data_readRegB);
    expect_val("restart_pwm", 32'h0);        compare(DATA_W'(pwm_out));

    if (sb_q.size() != 0) begin
      n_bad++;
      $error("FAIL scoreboard_leftover: %0d entries remain, required 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
